// File: rtl/ram_wbuf_if.sv
// Signal bundle for ram_wbuf: CPU request/response, SDRAM request port, buffer status and FSM state.
interface ram_wbuf_if #(
   parameter int AW    = 25,
   parameter int DW    = 32,
   parameter int DEPTH = 4
);
   localparam int LW = $clog2(DEPTH) + 1;

   // Handshake: the CPU holds stb (with we/addr/data_in) until a one-cycle ack and may
   // present a new request only after ack; the block holds mem_stb/mem_we/mem_addr/mem_din
   // stable until a one-cycle mem_ack, which is ignored when no request is outstanding.
   logic          stb;
   logic          we;
   logic [AW-1:0] addr;
   logic [DW-1:0] data_in;
   logic [DW-1:0] data_out;
   logic          ack;
   logic          mem_stb;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_din;
   logic [DW-1:0] mem_dout;
   logic          mem_ack;
   logic [LW-1:0] wbuf_level;
   logic [1:0]    fsm_state;

   modport slave (
      input  stb, we, addr, data_in, mem_dout, mem_ack,
      output data_out, ack, mem_stb, mem_we, mem_addr, mem_din, wbuf_level, fsm_state
   );

   modport master (
      output stb, we, addr, data_in, mem_dout, mem_ack,
      input  data_out, ack, mem_stb, mem_we, mem_addr, mem_din, wbuf_level, fsm_state
   );
endinterface

// File: rtl/ram_wbuf.sv
// RAM front-end with a DEPTH-entry posted-write FIFO drained in order; reads wait for drain.
// Define RAM_WBUF_FWD_EN to let reads that hit a buffered address complete from the buffer.
module ram_wbuf #(
   parameter int AW    = 25,
   parameter int DW    = 32,
   parameter int DEPTH = 4
) (
   input logic       clk,
   input logic       rst,
   ram_wbuf_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2
   } state_t;

   state_t        state_q, state_d;
   logic          ack_q, ack_d;
   logic [DW-1:0] data_out_q, data_out_d;
   logic          mem_stb_q, mem_stb_d;
   logic          mem_we_q, mem_we_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_din_q, mem_din_d;
   logic [AW-1:0] fifo_addr_q [DEPTH];
   logic [AW-1:0] fifo_addr_d [DEPTH];
   logic [DW-1:0] fifo_data_q [DEPTH];
   logic [DW-1:0] fifo_data_d [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] level_q, level_d;

   logic          req;
   logic          push;
   logic          pop;
   logic          rd_accept;
   logic          fwd_rd;
   logic          fwd_hit;
   logic [DW-1:0] fwd_data;

   // A request is only sampled while ack is low, so a held stb is never counted twice.
   always_comb begin
      req       = bus.stb & ~ack_q;
      push      = req & bus.we & (level_q < LW'(DEPTH));
      rd_accept = req & ~bus.we & (level_q == '0) & (state_q == IDLE);
      pop       = (state_q == WR) & bus.mem_ack;
      fwd_rd    = req & ~bus.we & fwd_hit;
   end

`ifdef RAM_WBUF_FWD_EN
   logic [PW-1:0] fwd_idx;

   // Scan oldest to newest so the newest matching entry wins.
   always_comb begin
      fwd_hit  = 1'b0;
      fwd_data = '0;
      fwd_idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q + PW'(i);
         if ((LW'(i) < level_q) && (fifo_addr_q[fwd_idx] == bus.addr)) begin
            fwd_hit  = 1'b1;
            fwd_data = fifo_data_q[fwd_idx];
         end
      end
   end
`else
   assign fwd_hit  = 1'b0;
   assign fwd_data = '0;
`endif

   always_comb begin
      state_d     = state_q;
      ack_d       = 1'b0;
      data_out_d  = data_out_q;
      mem_stb_d   = mem_stb_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_din_d   = mem_din_q;
      fifo_addr_d = fifo_addr_q;
      fifo_data_d = fifo_data_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q + LW'(push) - LW'(pop);

      if (push) begin
         fifo_addr_d[wr_ptr_q] = bus.addr;
         fifo_data_d[wr_ptr_q] = bus.data_in;
         wr_ptr_d              = wr_ptr_q + PW'(1);
         ack_d                 = 1'b1;
      end
      if (fwd_rd) begin
         data_out_d = fwd_data;
         ack_d      = 1'b1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end

      case (state_q)
         IDLE: begin
            // rd_accept needs an empty buffer, so a pending drain always goes first.
            if (rd_accept) begin
               state_d    = RD;
               mem_stb_d  = 1'b1;
               mem_we_d   = 1'b0;
               mem_addr_d = bus.addr;
            end else if (level_q != '0) begin
               state_d    = WR;
               mem_stb_d  = 1'b1;
               mem_we_d   = 1'b1;
               mem_addr_d = fifo_addr_q[rd_ptr_q];
               mem_din_d  = fifo_data_q[rd_ptr_q];
            end
         end
         WR: begin
            if (bus.mem_ack) begin
               state_d   = IDLE;
               mem_stb_d = 1'b0;
               mem_we_d  = 1'b0;
            end
         end
         RD: begin
            if (bus.mem_ack) begin
               state_d    = IDLE;
               mem_stb_d  = 1'b0;
               data_out_d = bus.mem_dout;
               ack_d      = 1'b1;
            end
         end
         default: begin
            state_d   = IDLE;
            mem_stb_d = 1'b0;
            mem_we_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         ack_q      <= 1'b0;
         data_out_q <= '0;
         mem_stb_q  <= 1'b0;
         mem_we_q   <= 1'b0;
         mem_addr_q <= '0;
         mem_din_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            fifo_addr_q[i] <= '0;
            fifo_data_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ack_q       <= ack_d;
         data_out_q  <= data_out_d;
         mem_stb_q   <= mem_stb_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_din_q   <= mem_din_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         fifo_addr_q <= fifo_addr_d;
         fifo_data_q <= fifo_data_d;
      end
   end

   assign bus.ack        = ack_q;
   assign bus.data_out   = data_out_q;
   assign bus.mem_stb    = mem_stb_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_din    = mem_din_q;
   assign bus.wbuf_level = level_q;
   assign bus.fsm_state  = state_q;
endmodule

// File: tb/tb_ram_wbuf.sv
// Directed bench for ram_wbuf: CPU driver tasks, a delay-programmable memory responder and
// an in-order scoreboard of expected memory writes.
module tb_ram_wbuf;
   localparam int AW    = 25;
   localparam int DW    = 32;
   localparam int DEPTH = 4;
   localparam int EW    = AW + DW;

   logic clk = 1'b0;
   logic rst = 1'b1;

   ram_wbuf_if #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) bus ();

   ram_wbuf #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int            n_checks  = 0;
   int            n_err     = 0;
   logic [EW-1:0] exp_q[$];
   int            mem_delay = 3;
   bit            mem_hold  = 1'b0;
   logic [DW-1:0] rd_data   = '0;
   int            n_mem_rd  = 0;
   int            n_mem_wr  = 0;
   int            spur_req  = 0;
   int            spur_done = 0;
   int            cnt       = 0;

   // ---------------- clock / watchdog ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- memory responder + scoreboard ----------------
   initial begin
      bus.mem_ack  = 1'b0;
      bus.mem_dout = '0;
      forever begin
         @(negedge clk);
         if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
         end else if (spur_req != spur_done) begin
            spur_done   = spur_req;
            bus.mem_ack = 1'b1;
         end else if (rst || !bus.mem_stb) begin
            cnt = 0;
         end else begin
            cnt++;
            if (!mem_hold && cnt >= mem_delay) begin
               cnt         = 0;
               bus.mem_ack = 1'b1;
               if (bus.mem_we) begin
                  n_mem_wr++;
                  check("mem_wr_expected", exp_q.size() != 0, 1'b1);
                  if (exp_q.size() != 0)
                     check("mem_wr_order", {bus.mem_addr, bus.mem_din}, exp_q.pop_front());
               end else begin
                  n_mem_rd++;
                  bus.mem_dout = rd_data;
                  check("mem_rd_after_drain", exp_q.size(), 0);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cpu_write(input logic [AW-1:0] a, input logic [DW-1:0] d, output int lat);
      bus.stb     = 1'b1;
      bus.we      = 1'b1;
      bus.addr    = a;
      bus.data_in = d;
      lat         = 0;
      exp_q.push_back({a, d});
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.ack && lat < 100);
      check("wr_ack_seen", bus.ack, 1'b1);
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      @(negedge clk);
   endtask

   task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int lat);
      bus.stb  = 1'b1;
      bus.we   = 1'b0;
      bus.addr = a;
      lat      = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!bus.ack && lat < 100);
      check("rd_ack_seen", bus.ack, 1'b1);
      d       = bus.data_out;
      bus.stb = 1'b0;
      @(negedge clk);
   endtask

   task automatic wait_level(input int lvl, input string tag);
      int n = 0;
      while (bus.wbuf_level != lvl && n < 200) begin
         @(negedge clk);
         n++;
      end
      check(tag, bus.wbuf_level, lvl);
   endtask

   task automatic wait_ack(input string tag);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.ack && n < 50);
      check(tag, bus.ack, 1'b1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int            lat;
      int            n;
      int            base_rd;
      int            base_wr;
      logic [DW-1:0] rdv;

      bus.stb     = 1'b0;
      bus.we      = 1'b0;
      bus.addr    = '0;
      bus.data_in = '0;
      repeat (2) @(negedge clk);

      check("rst_ack", bus.ack, 1'b0);
      check("rst_mem_stb", bus.mem_stb, 1'b0);
      check("rst_mem_we", bus.mem_we, 1'b0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_mem_din", bus.mem_din, 0);
      check("rst_data_out", bus.data_out, 0);
      check("rst_level", bus.wbuf_level, 0);
      check("rst_state", bus.fsm_state, 0);
      rst = 1'b0;
      @(negedge clk);

      // single posted write, memory answers 3 cycles after mem_stb
      mem_delay = 3;
      cpu_write(25'h10, 32'hDEADBEEF, lat);
      check("s1_wr_lat", lat, 1);
      check("s1_level_1", bus.wbuf_level, 1);
      n = 0;
      while (!bus.mem_stb && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("s1_mem_stb", bus.mem_stb, 1'b1);
      check("s1_mem_we", bus.mem_we, 1'b1);
      check("s1_mem_addr", bus.mem_addr, 25'h10);
      check("s1_mem_din", bus.mem_din, 32'hDEADBEEF);
      wait_level(0, "s1_level_0");

      // fill the buffer with memory held off, fifth write must stall until a pop
      mem_hold  = 1'b1;
      mem_delay = 1;
      for (int i = 0; i < 4; i++) begin
         cpu_write(25'h100 + AW'(i), 32'hA0 + DW'(i), lat);
         check("s2_wr_lat", lat, 1);
      end
      check("s2_level_full", bus.wbuf_level, 4);
      bus.stb     = 1'b1;
      bus.we      = 1'b1;
      bus.addr    = 25'h104;
      bus.data_in = 32'hA4;
      exp_q.push_back({25'h104, 32'hA4});
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("s2_fifth_stalled", bus.ack, 1'b0);
      end
      check("s2_level_held", bus.wbuf_level, 4);
      #1 mem_hold = 1'b0;
      wait_ack("s2_fifth_ack");
      check("s2_level_after_pop_push", bus.wbuf_level, 4);
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      @(negedge clk);
      mem_delay = 2;
      wait_level(0, "s2_drained");
      check("s2_sb_empty", exp_q.size(), 0);

      // read right behind a write to the same address
      mem_delay = 3;
      rd_data   = 32'h11111111;
      base_rd   = n_mem_rd;
      cpu_write(25'h20, 32'h11111111, lat);
      cpu_read(25'h20, rdv, lat);
`ifdef RAM_WBUF_FWD_EN
      check("s3_fwd_lat", lat, 1);
      check("s3_fwd_no_mem_rd", n_mem_rd, base_rd);
`else
      check("s3_mem_rd_once", n_mem_rd, base_rd + 1);
`endif
      check("s3_data", rdv, 32'h11111111);
      wait_level(0, "s3_drained");

`ifdef RAM_WBUF_FWD_EN
      mem_hold = 1'b1;
      base_rd  = n_mem_rd;
      cpu_write(25'h50, 32'hAAAA0001, lat);
      cpu_write(25'h50, 32'hBBBB0002, lat);
      cpu_read(25'h50, rdv, lat);
      check("fwd_newest_lat", lat, 1);
      check("fwd_newest_data", rdv, 32'hBBBB0002);
      check("fwd_newest_no_mem_rd", n_mem_rd, base_rd);
      #1 mem_hold = 1'b0;
      wait_level(0, "fwd_drained");
`endif

      // read on an empty buffer, mem_ack sampled 4 edges after the read is taken
      mem_delay = 4;
      rd_data   = 32'hCAFEF00D;
      base_rd   = n_mem_rd;
      base_wr   = n_mem_wr;
      cpu_read(25'h30, rdv, lat);
      check("s4_rd_lat", lat, 5);
      check("s4_data", rdv, 32'hCAFEF00D);
      check("s4_one_mem_rd", n_mem_rd, base_rd + 1);
      check("s4_no_mem_wr", n_mem_wr, base_wr);
      check("s4_data_held", bus.data_out, 32'hCAFEF00D);

      // stray mem_ack while idle has no effect
      #1 spur_req++;
      @(negedge clk);
      @(negedge clk);
      check("spur_level", bus.wbuf_level, 0);
      check("spur_ack", bus.ack, 1'b0);
      check("spur_mem_stb", bus.mem_stb, 1'b0);
      check("spur_state", bus.fsm_state, 0);
      check("spur_data_out", bus.data_out, 32'hCAFEF00D);

      // asynchronous reset in the middle of a drain with three entries buffered
      mem_hold  = 1'b1;
      mem_delay = 3;
      cpu_write(25'h60, 32'h60, lat);
      cpu_write(25'h61, 32'h61, lat);
      bus.stb     = 1'b1;
      bus.we      = 1'b1;
      bus.addr    = 25'h62;
      bus.data_in = 32'h62;
      exp_q.push_back({25'h62, 32'h62});
      @(negedge clk);
      check("s5_pre_ack", bus.ack, 1'b1);
      check("s5_pre_level", bus.wbuf_level, 3);
      check("s5_pre_mem_stb", bus.mem_stb, 1'b1);
      check("s5_pre_state", bus.fsm_state, 1);
      #2 rst = 1'b1;
      #1;
      check("s5_rst_ack", bus.ack, 1'b0);
      check("s5_rst_mem_stb", bus.mem_stb, 1'b0);
      check("s5_rst_level", bus.wbuf_level, 0);
      check("s5_rst_state", bus.fsm_state, 0);
      check("s5_rst_data_out", bus.data_out, 0);
      bus.stb  = 1'b0;
      bus.we   = 1'b0;
      exp_q.delete();
      mem_hold = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      cpu_write(25'h10, 32'hDEADBEEF, lat);
      check("s5_wr_lat", lat, 1);
      check("s5_level_1", bus.wbuf_level, 1);
      wait_level(0, "s5_level_0");
      check("s5_sb_empty", exp_q.size(), 0);

      // stb held through ack, then a new write on the same strobe
      mem_hold    = 1'b1;
      bus.stb     = 1'b1;
      bus.we      = 1'b1;
      bus.addr    = 25'h40;
      bus.data_in = 32'h44440000;
      exp_q.push_back({25'h40, 32'h44440000});
      wait_ack("s6_first_ack");
      check("s6_level_1", bus.wbuf_level, 1);
      @(negedge clk);
      check("s6_ack_one_cycle", bus.ack, 1'b0);
      check("s6_no_double_push", bus.wbuf_level, 1);
      bus.addr    = 25'h41;
      bus.data_in = 32'h44440001;
      exp_q.push_back({25'h41, 32'h44440001});
      wait_ack("s6_second_ack");
      check("s6_level_2", bus.wbuf_level, 2);
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      @(negedge clk);
      check("s6_level_still_2", bus.wbuf_level, 2);
      #1 mem_hold = 1'b0;
      wait_level(0, "s6_drained");
      check("s6_sb_empty", exp_q.size(), 0);
      check("s6_data_out_untouched", bus.data_out, 0);

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end
endmodule
